// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of an external N-input gate: drive each vector, settle, sample, count mismatches.
// Optional GATE_SWEEP_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_sweep_checker #(
  parameter int N      = 3,
  parameter int SETTLE = 5,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             y_in,
  output logic [N-1:0]     x_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     first_fail,
  output logic             first_fail_vld
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [N-1:0]     x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [N-1:0]     ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             pass_q, pass_d;
  logic             exp_y, mismatch, last_vec, stop_hit, run_end;

  always_comb begin
    exp_y = 1'b0;
    case (mode_q)
      3'd0:    exp_y = &x_q;
      3'd1:    exp_y = |x_q;
      3'd2:    exp_y = ~&x_q;
      3'd3:    exp_y = ~|x_q;
      3'd4:    exp_y = ^x_q;
      3'd5:    exp_y = ~^x_q;
      3'd6:    exp_y = 1'b0;
      default: exp_y = 1'b1;
    endcase
  end

  assign mismatch = (y_in != exp_y);
  assign last_vec = (x_q == '1);
  assign err_inc  = (err_q == '1) ? err_q : err_q + 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif
  assign run_end  = last_vec || stop_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNT_LAST) state_d = S_CHECK;
      S_CHECK:  state_d = run_end ? S_DONE : S_SETTLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SETTLE) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
  end

  // Datapath next-state; results hold everywhere except on accepted start and CHECK
  always_comb begin
    mode_d = mode_q;
    x_d    = x_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    ff_d   = ff_q;
    ffv_d  = ffv_q;
    pass_d = pass_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode;
        x_d    = '0;
        cnt_d  = '0;
        err_d  = '0;
        ffv_d  = 1'b0;
        pass_d = 1'b0;
      end
      S_SETTLE: cnt_d = cnt_q + 1'b1;
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!ffv_q) begin
            ff_d  = x_q;
            ffv_d = 1'b1;
          end
        end
        if (run_end) begin
          pass_d = (err_d == '0);
        end else begin
          x_d   = x_q + 1'b1;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      x_q    <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      ff_q   <= '0;
      ffv_q  <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      ffv_q  <= ffv_d;
      pass_q <= pass_d;
    end
  end

  assign x_out          = x_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three configurations driven by a fault-injecting gate model.
`timescale 1ns/1ps
module tb_gate_sweep_checker;

  localparam int NB [3] = '{3, 4, 3};
  localparam int SL [3] = '{5, 1, 5};
  localparam int EW [3] = '{8, 8, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start_s [3];
  logic [2:0]  mode_s  [3];
  logic        y_s     [3];
  logic [2:0]  mode_m  [3];
  logic [15:0] fmask   [3];

  logic [2:0] x0, ff0, x2, ff2;
  logic [3:0] x1, ff1;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic b0, b1, b2, d0, d1, d2, p0, p1, p2, v0, v1, v2;

  logic [3:0] xo [3], ffo [3];
  logic [7:0] erro [3];
  logic bo [3], dn [3], ps [3], fv [3];

  int checks = 0;
  int failures = 0;

  gate_sweep_checker #(.N(3), .SETTLE(5), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .y_in(y_s[0]),
    .x_out(x0), .busy(b0), .done(d0), .pass(p0), .err_cnt(err0),
    .first_fail(ff0), .first_fail_vld(v0));
  gate_sweep_checker #(.N(4), .SETTLE(1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .y_in(y_s[1]),
    .x_out(x1), .busy(b1), .done(d1), .pass(p1), .err_cnt(err1),
    .first_fail(ff1), .first_fail_vld(v1));
  gate_sweep_checker #(.N(3), .SETTLE(5), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode_s[2]), .y_in(y_s[2]),
    .x_out(x2), .busy(b2), .done(d2), .pass(p2), .err_cnt(err2),
    .first_fail(ff2), .first_fail_vld(v2));

  always_comb begin
    xo[0] = {1'b0, x0};   xo[1] = x1;   xo[2] = {1'b0, x2};
    ffo[0] = {1'b0, ff0}; ffo[1] = ff1; ffo[2] = {1'b0, ff2};
    erro[0] = err0; erro[1] = err1; erro[2] = {6'd0, err2};
    bo[0] = b0; bo[1] = b1; bo[2] = b2;
    dn[0] = d0; dn[1] = d1; dn[2] = d2;
    ps[0] = p0; ps[1] = p1; ps[2] = p2;
    fv[0] = v0; fv[1] = v1; fv[2] = v2;
  end

  // Ideal gate function from the count of ones in the vector
  function automatic logic ref_exp(input logic [2:0] m, input logic [3:0] x, input int n);
    int ones;
    ones = $countones(x);
    case (m)
      3'd0: return ones == n;
      3'd1: return ones > 0;
      3'd2: return ones != n;
      3'd3: return ones == 0;
      3'd4: return (ones % 2) == 1;
      3'd5: return (ones % 2) == 0;
      3'd6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Gate under test: ideal function for the model mode, inverted on vectors set in fmask
  always_comb begin
    for (int d = 0; d < 3; d++)
      y_s[d] = ref_exp(mode_m[d], xo[d], NB[d]) ^ fmask[d][xo[d]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int d, input logic [2:0] m, input logic [15:0] fm,
                     input bit poke, input string tag);
    int nv, pop, ffi, sat, e_busy, e_err, e_x, bc;
    logic [15:0] msk;
    nv  = 1 << NB[d];
    msk = fm & 16'((32'd1 << nv) - 1);
    pop = $countones(msk);
    sat = (1 << EW[d]) - 1;
    ffi = 0;
    for (int i = nv - 1; i >= 0; i--) if (msk[i]) ffi = i;
    e_busy = nv * (SL[d] + 1);
    e_err  = (pop > sat) ? sat : pop;
    e_x    = nv - 1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    if (pop > 0) begin
      e_busy = (ffi + 1) * (SL[d] + 1);
      e_err  = 1;
      e_x    = ffi;
    end
`endif
    mode_m[d] = m;
    fmask[d]  = msk;
    mode_s[d] = m;
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    bc = 0;
    while (bo[d] && bc < 2000) begin
      bc++;
      if (poke) begin
        start_s[d] = 1'($urandom_range(0, 1));
        mode_s[d]  = 3'($urandom);
      end
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    chk({tag, "/busy_cycles"}, bc, e_busy);
    chk({tag, "/done_pulse"}, dn[d], 1'b1);
    chk({tag, "/pass"}, ps[d], pop == 0);
    chk({tag, "/err_cnt"}, erro[d], e_err);
    chk({tag, "/ff_vld"}, fv[d], pop > 0);
    if (pop > 0) chk({tag, "/first_fail"}, ffo[d], ffi);
    chk({tag, "/x_out"}, xo[d], e_x);
    @(negedge clk);
    chk({tag, "/done_low"}, dn[d], 1'b0);
    chk({tag, "/idle_busy"}, bo[d], 1'b0);
    chk({tag, "/pass_held"}, ps[d], pop == 0);
    chk({tag, "/err_held"}, erro[d], e_err);
    chk({tag, "/x_held"}, xo[d], e_x);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] par_mask;
    logic [15:0] rmask;
    logic [7:0]  pre_mask;
    int w, pre_err, dcnt;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; mode_s[d] = 3'd0; mode_m[d] = 3'd0; fmask[d] = 16'd0;
    end
    #1;
    chk("rst/x_out", xo[0], 0);
    chk("rst/busy", bo[0], 0);
    chk("rst/done", dn[0], 0);
    chk("rst/pass", ps[0], 0);
    chk("rst/err", erro[0], 0);
    chk("rst/ff_vld", fv[0], 0);
    chk("rst/ff", ffo[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(0, 3'd0, 16'h0000, 1'b0, "and3");
    run(0, 3'd0, 16'h007E, 1'b0, "and3_vs_or3");
    run(1, 3'd4, 16'h0000, 1'b0, "xor4");
    par_mask = '0;
    for (int i = 0; i < 16; i++) par_mask[i] = ($countones(i) % 2) == 1;
    run(1, 3'd4, par_mask, 1'b0, "xor4_tied0");
    run(2, 3'd7, 16'h00FF, 1'b0, "sa1_sat");
    run(0, 3'd1, 16'h0000, 1'b1, "start_poke");

    // Abort a run while vector 4 is on the gate
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    pre_mask = 8'h00; pre_err = 0;
`else
    pre_mask = 8'h0F; pre_err = 4;
`endif
    mode_m[0] = 3'd0; fmask[0] = {8'd0, pre_mask}; mode_s[0] = 3'd0;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    w = 0;
    while (xo[0] != 4'd4 && w < 200) begin w++; @(negedge clk); end
    chk("abort/reach_v4", xo[0], 4);
    chk("abort/pre_err", erro[0], pre_err);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort/x_out", xo[0], 0);
    chk("abort/busy", bo[0], 0);
    chk("abort/done", dn[0], 0);
    chk("abort/err", erro[0], 0);
    chk("abort/ff_vld", fv[0], 0);
    chk("abort/pass", ps[0], 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (dn[0] || bo[0]) dcnt++;
    end
    chk("abort/no_done_after", dcnt, 0);
    run(0, 3'd0, 16'h0000, 1'b0, "after_abort");

    for (int k = 0; k < 14; k++) begin
      int d;
      d = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       rmask = 16'h0000;
        1:       rmask = 16'(1 << $urandom_range(0, 15));
        default: rmask = 16'($urandom & $urandom);
      endcase
      run(d, 3'($urandom), rmask, 1'($urandom_range(0, 1)), $sformatf("rand%0d_d%0d", k, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
